// File: rtl/multi_sensor_scan_pkg.sv
// scan_pkg: FSM state codes, ASCII command constants and BCD-to-ASCII helper for multi_sensor_scan
package scan_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    MEDE     = 4'd1,
    ESPERA   = 4'd2,
    ARMAZENA = 4'd3,
    TX_CHAR  = 4'd4,
    TX_WAIT  = 4'd5,
    PROX     = 4'd6,
    FIM      = 4'd7,
    PAUSA    = 4'd8
  } state_t;
  localparam logic [6:0] ASCII_0 = 7'h30;
  localparam logic [6:0] ASCII_C = 7'h43;
  localparam logic [6:0] ASCII_P = 7'h50;
  localparam logic [6:0] ASCII_M = 7'h4D;
  function automatic logic [6:0] bcd_to_ascii(input logic [3:0] nibble);
    return ASCII_0 + {3'b000, nibble};
  endfunction
endpackage

// File: rtl/multi_sensor_scan_sweep_timer.sv
// sweep_timer: saturating count-to-(MAX-1) counter; clr reloads zero, en advances, done flags the terminal count
module sweep_timer #(
  parameter int MAX = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int W = MAX > 1 ? $clog2(MAX) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign done = cnt_q == W'(MAX - 1);
  always_comb cnt_d = clr ? '0 : (en && !done) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multi_sensor_scan.sv
// multi_sensor_scan: triggers N_CH BCD range sensors in turn, latches each reading (timeout -> all F), streams the sweep as an ASCII frame over the TX start/ready handshake; single-shot or periodic, driven by ligar or rx 'M'/'C'/'P'
module multi_sensor_scan
  import scan_pkg::*;
#(
  parameter int         N_CH           = 3,
  parameter int         DIGITS         = 3,
  parameter int         TIMEOUT_CYCLES = 1_500_000,
  parameter int         PERIOD_CYCLES  = 50_000_000,
  parameter logic [6:0] SEP            = 7'h2C,
  parameter logic [6:0] TERM           = 7'h23
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ligar,
  output logic [N_CH-1:0]            medir,
  input  logic [N_CH-1:0]            pronto_medida,
  input  logic [N_CH*4*DIGITS-1:0]   medida,
  output logic                       partida_tx,
  output logic [6:0]                 dado_tx,
  input  logic                       pronto_tx,
  input  logic                       rx_valid,
  input  logic [6:0]                 rx_dado,
  output logic [N_CH*4*DIGITS-1:0]   medidas,
  output logic [N_CH-1:0]            timeout_flags,
  output logic                       continuo,
  output logic                       pronto,
  output logic [3:0]                 db_estado
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int DW = $clog2(DIGITS + 1);
  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic              hit_q, hit_d, continuo_q, continuo_d, partida_q, partida_d;
  logic [N_CH*BW-1:0] medidas_q, medidas_d;
  logic [N_CH-1:0]   flags_q, flags_d;
  logic [6:0]        dado_q, dado_d, chr;
  logic [3:0]        nib;
  logic              tmo_done, per_done, rx_c, rx_p, rx_m, got, last_ch, last_dig;
  assign rx_c     = rx_valid && rx_dado == ASCII_C;
  assign rx_p     = rx_valid && rx_dado == ASCII_P;
  assign rx_m     = rx_valid && rx_dado == ASCII_M;
  assign got      = pronto_medida[ch_q];
  assign last_ch  = ch_q == CW'(N_CH - 1);
  assign last_dig = dig_q == DW'(DIGITS);
  assign nib = medidas_q[(int'(ch_q) * DIGITS + (last_dig ? 0 : DIGITS - 1 - int'(dig_q))) * 4 +: 4];
  assign chr = !last_dig ? bcd_to_ascii(nib) : last_ch ? TERM : SEP;
  sweep_timer #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clock(clock), .reset(reset), .clr(state_q == MEDE), .en(state_q == ESPERA), .done(tmo_done)
  );
  // The period count starts in FIM so the next MEDE lands exactly PERIOD_CYCLES after FIM.
  sweep_timer #(.MAX(PERIOD_CYCLES)) u_period (
    .clock(clock), .reset(reset), .clr(!(state_q == FIM || state_q == PAUSA)), .en(1'b1), .done(per_done)
  );
  assign medir         = state_q == MEDE ? N_CH'(1) << ch_q : '0;
  assign pronto        = state_q == FIM;
  assign db_estado     = state_q;
  assign partida_tx    = partida_q;
  assign dado_tx       = dado_q;
  assign medidas       = medidas_q;
  assign timeout_flags = flags_q;
  assign continuo      = continuo_q;
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    dig_d      = dig_q;
    hit_d      = hit_q;
    medidas_d  = medidas_q;
    flags_d    = flags_q;
    partida_d  = 1'b0;
    dado_d     = dado_q;
    continuo_d = rx_c ? 1'b1 : rx_p ? 1'b0 : continuo_q;
    case (state_q)
      IDLE: begin
        ch_d = '0;
        if (ligar || rx_m || continuo_q) state_d = MEDE;
      end
      MEDE: state_d = ESPERA;
      ESPERA: if (got || tmo_done) begin
        hit_d   = got;
        state_d = ARMAZENA;
      end
      ARMAZENA: begin
        medidas_d[int'(ch_q)*BW +: BW] = hit_q ? medida[int'(ch_q)*BW +: BW] : '1;
        flags_d[ch_q] = !hit_q;
        dig_d   = '0;
        state_d = TX_CHAR;
      end
      TX_CHAR: begin
        partida_d = 1'b1;
        dado_d    = chr;
        state_d   = TX_WAIT;
      end
      TX_WAIT: if (pronto_tx) begin
        dig_d   = dig_q + 1'b1;
        state_d = last_dig ? PROX : TX_CHAR;
      end
      PROX: begin
        ch_d    = last_ch ? ch_q : ch_q + 1'b1;
        state_d = last_ch ? FIM : MEDE;
      end
      FIM: state_d = continuo_q ? PAUSA : IDLE;
      PAUSA: begin
        ch_d    = '0;
        state_d = !continuo_q ? IDLE : per_done ? MEDE : PAUSA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      dig_q      <= '0;
      hit_q      <= 1'b0;
      medidas_q  <= '0;
      flags_q    <= '0;
      continuo_q <= 1'b0;
      partida_q  <= 1'b0;
      dado_q     <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      dig_q      <= dig_d;
      hit_q      <= hit_d;
      medidas_q  <= medidas_d;
      flags_q    <= flags_d;
      continuo_q <= continuo_d;
      partida_q  <= partida_d;
      dado_q     <= dado_d;
    end
endmodule

// File: tb/tb_multi_sensor_scan.sv
// tb_multi_sensor_scan: scoreboard bench with randomized sensor/TX response against a frame-level reference model
module tb_multi_sensor_scan;
  localparam int N = 3, D = 3, TMO = 20, PER = 50, BW = 12;
  logic clock = 0, reset = 0, ligar = 0, pronto_tx = 0, rx_valid = 0;
  logic partida_tx, continuo, pronto;
  logic [N-1:0] medir, timeout_flags, pronto_medida = '0;
  logic [N*BW-1:0] medida = '0, medidas;
  logic [6:0] dado_tx, rx_dado = '0;
  logic [3:0] db_estado;
  int checks = 0, errors = 0, cyc = 0, tx_cnt = 0, pronto_cnt = 0, med0_t = 0, fim_t = 0, tx_dly = 1;
  int med_t[N];
  int pv[N], pd[N];
  logic [6:0] exp_chr[$];
  int exp_medir[$];
  logic [N-1:0] exp_flags[$];
  logic [N*BW-1:0] exp_meds[$];

  multi_sensor_scan #(.N_CH(N), .DIGITS(D), .TIMEOUT_CYCLES(TMO), .PERIOD_CYCLES(PER)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .medir(medir), .pronto_medida(pronto_medida),
    .medida(medida), .partida_tx(partida_tx), .dado_tx(dado_tx), .pronto_tx(pronto_tx),
    .rx_valid(rx_valid), .rx_dado(rx_dado), .medidas(medidas), .timeout_flags(timeout_flags),
    .continuo(continuo), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
  endtask

  function automatic logic [BW-1:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model: a channel answers in time iff its reply lands within TMO cycles of medir.
  task automatic push_plan();
    logic [N-1:0] f;
    logic [N*BW-1:0] m;
    string s;
    bit ok;
    f = '0;
    m = '0;
    for (int i = 0; i < N; i++) begin
      ok = pd[i] >= 1 && pd[i] <= TMO;
      medida[i*BW +: BW] = to_bcd(pv[i]);
      m[i*BW +: BW] = ok ? to_bcd(pv[i]) : '1;
      f[i] = !ok;
      if (ok) s = $sformatf("%03d", pv[i]);
      else s = "???";
      for (int k = 0; k < D; k++) exp_chr.push_back(7'(s[k]));
      exp_chr.push_back(i == N - 1 ? 7'h23 : 7'h2C);
      exp_medir.push_back(i);
    end
    exp_flags.push_back(f);
    exp_meds.push_back(m);
  endtask

  task automatic rand_plan();
    for (int i = 0; i < N; i++) begin
      pv[i] = int'($urandom_range(0, 999));
      if ($urandom_range(0, 4) == 0) pd[i] = -1;
      else pd[i] = int'($urandom_range(1, 26));
    end
    push_plan();
  endtask

  task automatic pulse_ligar();
    @(posedge clock); #1 ligar = 1;
    @(posedge clock); #1 ligar = 0;
  endtask

  task automatic send_rx(logic [6:0] c);
    @(posedge clock); #1 rx_valid = 1; rx_dado = c;
    @(posedge clock); #1 rx_valid = 0;
  endtask

  task automatic wait_pronto();
    int n0, i;
    n0 = pronto_cnt;
    i = 0;
    while (pronto_cnt == n0 && i < 5000) begin @(posedge clock); i++; end
    if (pronto_cnt == n0) fail("pronto wait");
  endtask

  task automatic wait_tx(int n);
    int n0, i;
    n0 = tx_cnt;
    i = 0;
    while (tx_cnt < n0 + n && i < 5000) begin @(negedge clock); i++; end
    if (tx_cnt < n0 + n) fail("partida_tx wait");
  endtask

  task automatic check_zero(string tag);
    chk({tag, " medir"}, 64'(medir), 64'(0));
    chk({tag, " partida_tx"}, 64'(partida_tx), 64'(0));
    chk({tag, " dado_tx"}, 64'(dado_tx), 64'(0));
    chk({tag, " pronto"}, 64'(pronto), 64'(0));
    chk({tag, " continuo"}, 64'(continuo), 64'(0));
    chk({tag, " db_estado"}, 64'(db_estado), 64'(0));
    chk({tag, " medidas"}, 64'(medidas), 64'(0));
    chk({tag, " timeout_flags"}, 64'(timeout_flags), 64'(0));
  endtask

  // Sensor side: reply on the triggered channel after pd cycles, plus a decoy pulse on another channel.
  initial begin
    int c, tend;
    forever begin
      @(negedge clock);
      if (medir != 0) begin
        c = 0;
        for (int i = 0; i < N; i++) if (medir[i]) c = i;
        tend = pd[c] > 0 ? pd[c] : 1;
        for (int t = 1; t <= tend; t++) begin
          @(posedge clock); #1;
          pronto_medida = t == pd[c] ? N'(1) << c : t == 1 ? N'(1) << ((c + 1) % N) : '0;
        end
        @(posedge clock); #1 pronto_medida = '0;
      end
    end
  end

  // Transmitter side: answer each partida_tx after tx_dly cycles (0 = random), checking dado_tx holds.
  initial begin
    logic [6:0] c;
    int d;
    forever begin
      @(negedge clock);
      if (partida_tx) begin
        c = dado_tx;
        d = tx_dly > 0 ? tx_dly : int'($urandom_range(1, 3));
        for (int i = 1; i < d; i++) begin
          @(posedge clock); #1;
          if (tx_dly > 1) chk("dado_tx stable", 64'(dado_tx), 64'(c));
        end
        @(posedge clock); #1 pronto_tx = 1;
        @(posedge clock); #1 pronto_tx = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a character, trigger or end of frame.
  always @(negedge clock) begin
    if (partida_tx) begin
      tx_cnt++;
      if (exp_chr.size() == 0) fail("unexpected partida_tx");
      else chk("dado_tx", 64'(dado_tx), 64'(exp_chr.pop_front()));
    end
    if (medir != 0) begin
      for (int i = 0; i < N; i++) if (medir[i]) med_t[i] = cyc;
      if (medir[0]) med0_t = cyc;
      if (exp_medir.size() == 0) fail("unexpected medir");
      else chk("medir", 64'(medir), 64'(N'(1) << exp_medir.pop_front()));
    end
    if (pronto) begin
      pronto_cnt++;
      fim_t = cyc;
      if (exp_flags.size() == 0) fail("unexpected pronto");
      else begin
        chk("timeout_flags", 64'(timeout_flags), 64'(exp_flags.pop_front()));
        chk("medidas", 64'(medidas), 64'(exp_meds.pop_front()));
        chk("frame complete", 64'(exp_chr.size()), 64'(0));
      end
    end
  end

  initial begin
    int f;
    repeat (3) @(posedge clock);
    #1 check_zero("reset");
    @(negedge clock) reset = 1;

    pv = '{123, 45, 300};
    pd = '{3, 5, 2};
    push_plan();
    pulse_ligar();
    @(negedge clock) chk("start latency medir", 64'(medir), 64'(1));
    wait_pronto();
    @(negedge clock) chk("idle after single", 64'(db_estado), 64'(0));

    pd = '{4, -1, 6};
    push_plan();
    pulse_ligar();
    wait_pronto();
    chk("timeout gap > TMO", 64'(med_t[2] - med_t[1] > TMO), 64'(1));

    pd = '{2, TMO, 1};
    push_plan();
    pulse_ligar();
    wait_pronto();
    pd = '{2, TMO + 1, 1};
    push_plan();
    send_rx(7'h4D);
    wait_pronto();

    send_rx(7'h41);
    repeat (10) @(posedge clock);
    chk("other char ignored", 64'(db_estado), 64'(0));

    tx_dly = 0;
    repeat (6) begin
      rand_plan();
      if ($urandom_range(0, 1) == 1) pulse_ligar();
      else send_rx(7'h4D);
      wait_pronto();
    end

    rand_plan();
    send_rx(7'h43);
    wait_pronto();
    f = fim_t;
    chk("continuo set", 64'(continuo), 64'(1));
    rand_plan();
    wait_tx(5);
    send_rx(7'h50);
    wait_pronto();
    chk("period gap", 64'(med0_t - f), 64'(PER));
    chk("continuo cleared", 64'(continuo), 64'(0));
    repeat (100) @(posedge clock);
    chk("idle after P", 64'(db_estado), 64'(0));

    tx_dly = 10;
    rand_plan();
    pulse_ligar();
    wait_tx(1);
    pulse_ligar();
    send_rx(7'h4D);
    wait_pronto();
    tx_dly = 0;
    repeat (40) @(posedge clock);
    chk("ligar in sweep ignored", 64'(db_estado), 64'(0));

    rand_plan();
    pulse_ligar();
    wait_tx(2);
    @(posedge clock);
    #3 reset = 0;
    #1 check_zero("async reset");
    exp_chr.delete();
    exp_medir.delete();
    exp_flags.delete();
    exp_meds.delete();
    repeat (3) @(posedge clock);
    #2 reset = 1;
    repeat (30) @(posedge clock);
    chk("idle after reset", 64'(db_estado), 64'(0));

    rand_plan();
    pulse_ligar();
    wait_pronto();
    repeat (5) @(posedge clock);
    chk("idle at end", 64'(db_estado), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
